jt51_kon_sched: RTL and testbench
=================================

// Module: jt51_kon_sched
// PURPOSE
//  Owns the 32-slot operator time base and key-on scheduling for the phase generator.
//  Runs the slot counter and the zero frame marker, and accepts CPU key-on/off
//  requests over a valid/ready handshake. Each request is applied on a frame boundary
//  and yields a per-slot key state plus a phase-reset pulse.
//  The pulse is aligned to the PG phase-reset input (stage III).
// PARAMETERS
//  RST_DELAY  2  clk_en-qualified stages between slot-I decision and pg_rst_III output (0..7)
//  FORCE_RST  0  1: pulse phase reset on every mask-bit-set slot (on->on too); 0: off->on only
// PORTS
//  clk        in   1  system clock; single clock domain
//  rst_n      in   1  reset; asynchronous assert, active-low
//  clk_en     in   1  slot advance enable; all slot-timed state moves only when high
//  kon_valid  in   1  key-on request present
//  kon_ready  out  1  request accepted on edge where kon_valid&&kon_ready
//  kon_ch     in   3  target channel 0..7
//  kon_mask   in   4  operator key state, bit n = operator n (1 on, 0 off)
//  zero       out  1  high while slot==0 (frame start marker for pipeline blocks)
//  slot       out  5  current slot, {op[1:0], ch[2:0]}
//  kon_I      out  1  key state of current slot's operator
//  pg_rst_III out  1  phase reset pulse, RST_DELAY clk_en stages after slot decision
//  busy       out  1  request held (ARMED or APPLY)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - slot=0, zero=1, FSM=IDLE, kon_ready=1, busy=0
//   - key-state vector (32b) cleared, kon_I=0, delay line and pg_rst_III=0
//  Slot counter: increments mod 32 on clk edges with clk_en=1; 31->0 wraps.
//   - zero = (slot==0), derived from the registered slot.
//   - clk_en=0 freezes slot, FSM frame progress and the delay line; handshake still works.
//  kon_I = keystate[slot], combinational from registered state.
//  FSM (kon_ready = IDLE):
//   - IDLE:  kon_valid=1 on any clk edge latches ch/mask -> ARMED. Inputs ignored otherwise.
//   - ARMED: on clk_en edge with slot==31 -> APPLY. The next frame starts at slot 0.
//            A request accepted while slot==31 still waits for the next slot==31 edge.
//   - APPLY: on each clk_en edge with slot[2:0]==latched ch:
//            keystate[slot] <= mask[slot[4:3]]
//            rst_i = mask bit & (FORCE_RST | ~old state)
//            On the clk_en edge with slot==31 -> IDLE. Exactly one full frame is applied.
//  Other slots: rst_i=0, keystate unchanged.
//   - The delay line shifts rst_i each clk_en edge.
//   - pg_rst_III = rst_i from RST_DELAY clk_en edges earlier; high for one clk_en period.
//   - RST_DELAY=0: pg_rst_III is combinational rst_i.
//  Key-off (mask bit 0) clears state and never pulses.
//  Request latency: acceptance to first possible pulse <= 64+RST_DELAY clk_en periods.
//  rst_n low mid-APPLY: partial frame updates remain cleared. No pulse is emitted after release.
//  Widths: slot wraps naturally in 5 bits. No arithmetic overflow elsewhere.
// TESTING
//  T1 reset:
//   - hold rst_n=0 -> slot=0, zero=1, kon_ready=1, busy=0, pg_rst_III=0, kon_I=0.
//   - release, clk_en=1 -> slot 0..31,0 with zero high once per 32.
//  T2 key-on:
//   - request ch=2 mask=4'b0001 at slot 5, RST_DELAY=2.
//   - -> APPLY next frame; pg_rst_III high exactly 2 clk_en after slot 2.
//   - -> kon_I=1 at slot 2 thereafter; slots 10,18,26 untouched.
//  T3 key-off, FORCE_RST:
//   - T2 then ch=2 mask=0 -> no pulse; kon_I=0 at slot 2.
//   - ch=2 mask=1 twice -> second gives no pulse if FORCE_RST=0, a pulse if FORCE_RST=1.
//  T4 handshake:
//   - kon_valid held with back-to-back requests -> kon_ready low until APPLY frame ends.
//   - second request applies in the following frame; requests at slot 31 wait a full extra frame.
//  T5 clk_en gating:
//   - clk_en 1-in-4 -> slot advances only on enabled edges.
//   - pulse width = one clk_en period; latency counted in enabled edges.
//  T6 mid-op reset:
//   - assert rst_n at APPLY slot 12 (ch=4 mask=4'hF) -> keystate all 0.
//   - -> FSM IDLE, no pg_rst_III pulse after release.

Source files
------------

// File: rtl/jt51_kon_sched.sv
// rtl/jt51_kon_sched.sv - 32-slot operator time base and frame-aligned key-on scheduler
//
// Purpose: runs the slot counter and frame-start marker, accepts one key-on/off
// request at a time and applies it over exactly one full frame, producing the
// per-slot key state and a phase-reset pulse aligned to the PG stage III input.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clk_en          slot advance enable (all slot-timed state moves only when high)
//   kon_valid/ready request handshake; kon_ch = channel 0..7, kon_mask = op key bits
//   zero            high while slot == 0
//   slot            current slot {op[1:0], ch[2:0]}
//   kon_I           key state of the current slot
//   pg_rst_III      phase-reset pulse, RST_DELAY enabled edges after the slot decision
//   busy            request held (ARMED or APPLY)

module jt51_kon_sched #(
  parameter int RST_DELAY = 2,
  parameter int FORCE_RST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       kon_valid,
  output logic       kon_ready,
  input  logic [2:0] kon_ch,
  input  logic [3:0] kon_mask,
  output logic       zero,
  output logic [4:0] slot,
  output logic       kon_I,
  output logic       pg_rst_III,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

  state_t      state_q, state_d;
  logic [4:0]  slot_q;
  logic [2:0]  ch_q, ch_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] keys_q, keys_d;

  logic last_slot;
  logic ch_hit;
  logic mask_bit;
  logic rst_i;

  // Decision for the slot currently presented (stage I).
  always_comb begin
    last_slot = (slot_q == 5'd31);
    ch_hit    = (state_q == APPLY) && (slot_q[2:0] == ch_q);
    mask_bit  = mask_q[slot_q[4:3]];
    rst_i     = ch_hit && mask_bit && ((FORCE_RST != 0) || !keys_q[slot_q]);
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    mask_d  = mask_q;
    keys_d  = keys_q;
    case (state_q)
      IDLE: begin
        // Acceptance does not depend on clk_en.
        if (kon_valid) begin
          ch_d    = kon_ch;
          mask_d  = kon_mask;
          state_d = ARMED;
        end
      end
      ARMED: begin
        // Wait for a frame boundary so the whole next frame is applied.
        if (clk_en && last_slot) state_d = APPLY;
      end
      APPLY: begin
        if (clk_en) begin
          if (ch_hit) keys_d[slot_q] = mask_bit;
          if (last_slot) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= 5'd0;
      ch_q    <= 3'd0;
      mask_q  <= 4'd0;
      keys_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      keys_q  <= keys_d;
      if (clk_en) slot_q <= slot_q + 5'd1;
    end
  end

  // Phase-reset alignment: a shift register clocked by clk_en, so the pulse
  // lasts one enabled period and latency is counted in enabled edges.
  generate
    if (RST_DELAY == 0) begin : g_nodly
      assign pg_rst_III = rst_i;
    end else begin : g_dly
      logic [RST_DELAY-1:0] dly_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly_q <= '0;
        end else if (clk_en) begin
          dly_q <= (dly_q << 1) | RST_DELAY'(rst_i);
        end
      end
      assign pg_rst_III = dly_q[RST_DELAY-1];
    end
  endgenerate

  assign slot      = slot_q;
  assign zero      = (slot_q == 5'd0);
  assign kon_I     = keys_q[slot_q];
  assign kon_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_jt51_kon_sched.sv
// tb/tb_jt51_kon_sched.sv - directed self-checking bench for jt51_kon_sched

module tb_jt51_kon_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic       kon_valid = 1'b0;
  logic [2:0] kon_ch = 3'd0;
  logic [3:0] kon_mask = 4'd0;

  logic       ready0, zero0, koni0, pg0, busy0;
  logic [4:0] slot0;
  logic       ready1, zero1, koni1, pg1, busy1;
  logic [4:0] slot1;
  logic       ready2, zero2, koni2, pg2, busy2;
  logic [4:0] slot2;

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_slot = 5'd0;

  always #5 clk = ~clk;

  jt51_kon_sched #(.RST_DELAY(2), .FORCE_RST(0)) d0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .kon_valid(kon_valid), .kon_ready(ready0),
    .kon_ch(kon_ch), .kon_mask(kon_mask), .zero(zero0), .slot(slot0), .kon_I(koni0),
    .pg_rst_III(pg0), .busy(busy0));

  jt51_kon_sched #(.RST_DELAY(2), .FORCE_RST(1)) d1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .kon_valid(kon_valid), .kon_ready(ready1),
    .kon_ch(kon_ch), .kon_mask(kon_mask), .zero(zero1), .slot(slot1), .kon_I(koni1),
    .pg_rst_III(pg1), .busy(busy1));

  jt51_kon_sched #(.RST_DELAY(0), .FORCE_RST(0)) d2 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .kon_valid(kon_valid), .kon_ready(ready2),
    .kon_ch(kon_ch), .kon_mask(kon_mask), .zero(zero2), .slot(slot2), .kon_I(koni2),
    .pg_rst_III(pg2), .busy(busy2));

  task automatic tick(input logic en);
    clk_en = en;
    @(posedge clk);
    #1;
    if (en) exp_slot = exp_slot + 5'd1;
  endtask

  task automatic run_to_slot(input logic [4:0] s, input int gap);
    for (int i = 0; i < 64 && exp_slot != s; i++) begin
      repeat (gap) tick(1'b0);
      tick(1'b1);
    end
    tests++;
    if (slot0 !== s) begin fails++; $display("FAIL run_to_slot: slot=%0d want %0d", slot0, s); end
  endtask

  task automatic send_req(input logic [2:0] ch, input logic [3:0] mask, input logic en);
    tests++;
    if (ready0 !== 1'b1) begin fails++; $display("FAIL req_ready: kon_ready=%b want 1", ready0); end
    kon_valid = 1'b1;
    kon_ch    = ch;
    kon_mask  = mask;
    tick(en);
    kon_valid = 1'b0;
    tests++;
    if (busy0 !== 1'b1) begin fails++; $display("FAIL req_busy: busy=%b want 1", busy0); end
  endtask

  // Starts at slot 0 of the APPLY frame; dec* mark the slots whose decision pulses.
  task automatic observe_apply(input logic [31:0] dec0, input logic [31:0] dec1, input int gap);
    logic e0, e1, e2;
    tests++;
    if (busy0 !== 1'b1) begin fails++; $display("FAIL apply_busy: busy=%b want 1", busy0); end
    for (int k = 0; k < 34; k++) begin
      e0 = 1'b0; e1 = 1'b0; e2 = 1'b0;
      if (k >= 2) begin e0 = dec0[k-2]; e1 = dec1[k-2]; end
      if (k < 32) e2 = dec0[k];
      for (int g = 0; g <= gap; g++) begin
        if (k == 32 && g == 0) begin
          tests++;
          if (busy0 !== 1'b0) begin fails++; $display("FAIL apply_end_busy: busy=%b want 0", busy0); end
        end
        tests++;
        if (slot0 !== 5'(k % 32)) begin fails++; $display("FAIL obs_slot k=%0d: slot=%0d want %0d", k, slot0, k % 32); end
        tests++;
        if (pg0 !== e0) begin fails++; $display("FAIL pg_d2f0 k=%0d g=%0d: got %b want %b", k, g, pg0, e0); end
        tests++;
        if (pg1 !== e1) begin fails++; $display("FAIL pg_d2f1 k=%0d g=%0d: got %b want %b", k, g, pg1, e1); end
        tests++;
        if (pg2 !== e2) begin fails++; $display("FAIL pg_d0f0 k=%0d g=%0d: got %b want %b", k, g, pg2, e2); end
        tick(g == gap);
      end
    end
  endtask

  task automatic check_keys(input logic [31:0] ks);
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (koni0 !== ks[exp_slot]) begin fails++; $display("FAIL kon_I0 slot=%0d: got %b want %b", exp_slot, koni0, ks[exp_slot]); end
      tests++;
      if (koni1 !== ks[exp_slot]) begin fails++; $display("FAIL kon_I1 slot=%0d: got %b want %b", exp_slot, koni1, ks[exp_slot]); end
      tick(1'b1);
    end
  endtask

  task automatic test_reset;
    int zc;
    rst_n = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (slot0 !== 5'd0) begin fails++; $display("FAIL rst_slot: got %0d want 0", slot0); end
    tests++; if (zero0 !== 1'b1) begin fails++; $display("FAIL rst_zero: got %b want 1", zero0); end
    tests++; if (ready0 !== 1'b1 || ready1 !== 1'b1 || ready2 !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b%b%b want 111", ready0, ready1, ready2); end
    tests++; if (busy0 !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b%b%b want 000", busy0, busy1, busy2); end
    tests++; if (pg0 !== 1'b0 || pg1 !== 1'b0 || pg2 !== 1'b0) begin fails++; $display("FAIL rst_pg: got %b%b%b want 000", pg0, pg1, pg2); end
    tests++; if (koni0 !== 1'b0 || koni1 !== 1'b0 || koni2 !== 1'b0) begin fails++; $display("FAIL rst_kon_I: got %b%b%b want 000", koni0, koni1, koni2); end
    tests++; if (slot1 !== 5'd0 || slot2 !== 5'd0 || zero1 !== 1'b1 || zero2 !== 1'b1) begin fails++; $display("FAIL rst_slot12: got %0d %0d", slot1, slot2); end
    rst_n = 1'b1;
    exp_slot = 5'd0;
    zc = 0;
    for (int i = 0; i < 33; i++) begin
      tests++;
      if (slot0 !== exp_slot) begin fails++; $display("FAIL count_slot i=%0d: got %0d want %0d", i, slot0, exp_slot); end
      tests++;
      if (zero0 !== (exp_slot == 5'd0)) begin fails++; $display("FAIL count_zero i=%0d: got %b", i, zero0); end
      if (zero0 === 1'b1) zc++;
      tick(1'b1);
    end
    tests++;
    if (zc != 2) begin fails++; $display("FAIL zero_count: got %0d want 2", zc); end
  endtask

  task automatic test_key_on;
    run_to_slot(5'd5, 0);
    send_req(3'd2, 4'b0001, 1'b1);
    run_to_slot(5'd0, 0);
    observe_apply(32'h4, 32'h4, 0);
    check_keys(32'h4);
  endtask

  task automatic test_key_off_force;
    send_req(3'd2, 4'b0000, 1'b1);
    run_to_slot(5'd0, 0);
    observe_apply(32'h0, 32'h0, 0);
    check_keys(32'h0);
    send_req(3'd2, 4'b0001, 1'b1);
    run_to_slot(5'd0, 0);
    observe_apply(32'h4, 32'h4, 0);
    send_req(3'd2, 4'b0001, 1'b1);
    run_to_slot(5'd0, 0);
    observe_apply(32'h0, 32'h4, 0);
    check_keys(32'h4);
  endtask

  task automatic test_back_to_back;
    int cnt;
    run_to_slot(5'd10, 0);
    kon_valid = 1'b1;
    kon_ch    = 3'd1;
    kon_mask  = 4'b0011;
    tick(1'b1);
    kon_ch    = 3'd3;
    kon_mask  = 4'b0010;
    cnt = 0;
    while (ready0 !== 1'b1 && cnt < 100) begin
      cnt++;
      tick(1'b1);
    end
    tests++;
    if (cnt != 53) begin fails++; $display("FAIL b2b_ready_low: cycles=%0d want 53", cnt); end
    tick(1'b1);
    kon_valid = 1'b0;
    tests++;
    if (busy0 !== 1'b1) begin fails++; $display("FAIL b2b_second_accept: busy=%b want 1", busy0); end
    run_to_slot(5'd0, 0);
    observe_apply(32'h800, 32'h800, 0);
    check_keys(32'hA06);
    run_to_slot(5'd31, 0);
    send_req(3'd5, 4'b0001, 1'b1);
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (pg0 !== 1'b0 || busy0 !== 1'b1) begin fails++; $display("FAIL slot31_wait i=%0d: pg=%b busy=%b want 0 1", i, pg0, busy0); end
      tick(1'b1);
    end
    observe_apply(32'h20, 32'h20, 0);
    check_keys(32'hA26);
  endtask

  task automatic test_clk_en_gating;
    logic [4:0] s;
    s = slot0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      tests++;
      if (slot0 !== s) begin fails++; $display("FAIL gate_freeze i=%0d: slot=%0d want %0d", i, slot0, s); end
    end
    send_req(3'd6, 4'b0100, 1'b0);
    tests++;
    if (slot0 !== s) begin fails++; $display("FAIL gate_req_slot: slot=%0d want %0d", slot0, s); end
    run_to_slot(5'd0, 3);
    observe_apply(32'h400000, 32'h400000, 3);
    check_keys(32'h400A26);
  endtask

  task automatic test_mid_reset;
    send_req(3'd4, 4'hF, 1'b1);
    run_to_slot(5'd0, 0);
    run_to_slot(5'd12, 0);
    rst_n = 1'b0;
    #1;
    tests++; if (slot0 !== 5'd0 || zero0 !== 1'b1) begin fails++; $display("FAIL midrst_slot: slot=%0d zero=%b", slot0, zero0); end
    tests++; if (busy0 !== 1'b0 || ready0 !== 1'b1) begin fails++; $display("FAIL midrst_fsm: busy=%b ready=%b want 0 1", busy0, ready0); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_slot = 5'd0;
    for (int i = 0; i < 40; i++) begin
      tests++;
      if (pg0 !== 1'b0 || pg1 !== 1'b0 || pg2 !== 1'b0 || busy0 !== 1'b0) begin
        fails++; $display("FAIL midrst_quiet i=%0d: pg=%b%b%b busy=%b", i, pg0, pg1, pg2, busy0);
      end
      tick(1'b1);
    end
    check_keys(32'h0);
  endtask

  initial begin
    test_reset();
    test_key_on();
    test_key_off_force();
    test_back_to_back();
    test_clk_en_gating();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
